clock_core_multi_alarm: RTL and testbench

Parametrised successor to the team's 12-hour clock/bell top. Keeps a BCD hh:mm:ss timebase with selectable 12/24-hour display and a hourly chime. Runs from a single clock with a tick prescaler and uses qualified enables instead of gated adjust clocks. Provides NUM_ALARMS independent alarm channels, each with its own ring/snooze state machine. Sits between the 1 Hz clock source and the BCD-to-7-segment decoders.

---
 rtl/clock_core_multi_alarm.sv | 275 +++++++++++++++++++++++++++
 tb/tb_clock_core_multi_alarm.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core_multi_alarm.sv
// ---------------------------------------------------------------------------
// clock_core_multi_alarm
//
// BCD hh:mm:ss timebase with a 12/24-hour display, an hourly chime and
// NUM_ALARMS independent alarm channels, each with its own ring/snooze
// state machine. Everything runs on CP; the one-second tick comes from a
// prescaler, and the adjust inputs act as qualified enables on that tick.
//
// Ports
//   CP         system clock (rising edge)
//   CR         synchronous active-high reset, highest priority
//   EN         run enable for prescaler and ticks
//   Adj_M      minute +1 per tick while high (no hour carry)
//   Adj_H      hour +1 per tick while high
//   Mode24     1 = 24-hour display, 0 = 12-hour display
//   Ld         time load strobe with Ld_Hour / Ld_Min (BCD)
//   Al_Wr      alarm write strobe with Al_Sel / Al_Hour / Al_Min (BCD)
//   Al_En      per-channel arm level
//   Snooze     snooze strobe (ringing channels only)
//   Stop       stop-all strobe, wins over Snooze
//   Hour       displayed hour BCD (mode dependent)
//   Minute     BCD minute
//   Second     BCD second
//   PM         internal hour >= 12
//   Tick       one-cycle second tick
//   HourRadio  one-cycle chime on the natural 59:59 -> 00:00 carry
//   Ring       per-channel ringing level
//   BellRadio  OR of Ring
//   Err        one-cycle pulse, the cycle after a rejected Ld or Al_Wr
// ---------------------------------------------------------------------------
module clock_core_multi_alarm #(
    parameter int NUM_ALARMS = 2,
    parameter int TICK_DIV   = 1,
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  CP,
    input  logic                  CR,
    input  logic                  EN,
    input  logic                  Adj_M,
    input  logic                  Adj_H,
    input  logic                  Mode24,
    input  logic                  Ld,
    input  logic [7:0]            Ld_Hour,
    input  logic [7:0]            Ld_Min,
    input  logic                  Al_Wr,
    input  logic [((NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1)-1:0] Al_Sel,
    input  logic [7:0]            Al_Hour,
    input  logic [7:0]            Al_Min,
    input  logic [NUM_ALARMS-1:0] Al_En,
    input  logic                  Snooze,
    input  logic                  Stop,
    output logic [7:0]            Hour,
    output logic [7:0]            Minute,
    output logic [7:0]            Second,
    output logic                  PM,
    output logic                  Tick,
    output logic                  HourRadio,
    output logic [NUM_ALARMS-1:0] Ring,
    output logic                  BellRadio,
    output logic                  Err
);

    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]       RING_LOAD   = 10'(RING_SECS);
    localparam logic [9:0]       SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } al_state_t;

    // Valid BCD byte no larger than max_v (BCD compares like binary once
    // both nibbles are decimal digits).
    function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pre_cnt;
    logic [7:0]       hour_q, min_q, sec_q;
    logic [7:0]       hour_n, min_n, sec_n;
    logic             tick, ld_ok, wr_ok, ld_take, time_step;
    logic             sec_wrap, min_wrap;
    logic             err_q;

    assign tick      = EN && (pre_cnt == CNT_LAST);
    assign ld_ok     = bcd_ok(Ld_Hour, 8'h23) && bcd_ok(Ld_Min, 8'h59);
    assign wr_ok     = bcd_ok(Al_Hour, 8'h23) && bcd_ok(Al_Min, 8'h59) &&
                       (int'(Al_Sel) < NUM_ALARMS);
    assign ld_take   = Ld && ld_ok;
    // A valid load owns the cycle; the tick that would have landed is lost.
    assign time_step = tick && !ld_take;

    // Next time on a tick. Adjust overrides the natural carry into its
    // field, and an adjusted minute never carries into the hour.
    always_comb begin
        sec_wrap = (sec_q == 8'h59);
        min_wrap = (min_q == 8'h59);
        sec_n    = bcd_inc(sec_q, 8'h59);
        min_n    = min_q;
        hour_n   = hour_q;
        if (Adj_M || sec_wrap)
            min_n = bcd_inc(min_q, 8'h59);
        if (Adj_H || (sec_wrap && min_wrap && !Adj_M))
            hour_n = bcd_inc(hour_q, 8'h23);
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            pre_cnt <= '0;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
        end else if (ld_take) begin
            pre_cnt <= '0;
            hour_q  <= Ld_Hour;
            min_q   <= Ld_Min;
            sec_q   <= 8'h00;
        end else if (EN) begin
            pre_cnt <= (pre_cnt == CNT_LAST) ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                hour_q <= hour_n;
                min_q  <= min_n;
                sec_q  <= sec_n;
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CR)
            err_q <= 1'b0;
        else
            err_q <= (Ld && !ld_ok) || (Al_Wr && !wr_ok);
    end

    // ------------------------------------------------------------------
    // Display
    // ------------------------------------------------------------------
    logic [4:0] hour_bin, disp_bin;

    always_comb begin
        hour_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
        if (Mode24)
            disp_bin = hour_bin;
        else if (hour_bin == 5'd0)
            disp_bin = 5'd12;
        else if (hour_bin > 5'd12)
            disp_bin = hour_bin - 5'd12;
        else
            disp_bin = hour_bin;
        if (disp_bin >= 5'd20)
            Hour = {4'd2, 4'(disp_bin - 5'd20)};
        else if (disp_bin >= 5'd10)
            Hour = {4'd1, 4'(disp_bin - 5'd10)};
        else
            Hour = {4'd0, 4'(disp_bin)};
    end

    assign Minute    = min_q;
    assign Second    = sec_q;
    assign PM        = (hour_bin >= 5'd12);
    assign Tick      = tick;
    assign HourRadio = time_step && sec_wrap && min_wrap && !Adj_M;
    assign Err       = err_q;

    // ------------------------------------------------------------------
    // Alarm settings
    // ------------------------------------------------------------------
    logic [7:0] al_hour [NUM_ALARMS];
    logic [7:0] al_min  [NUM_ALARMS];

    always_ff @(posedge CP) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (CR) begin
                al_hour[i] <= 8'h00;
                al_min[i]  <= 8'h00;
            end else if (Al_Wr && wr_ok && (Al_Sel == SEL_W'(i))) begin
                al_hour[i] <= Al_Hour;
                al_min[i]  <= Al_Min;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel alarm FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    al_state_t  state_q [NUM_ALARMS];
    al_state_t  state_n [NUM_ALARMS];
    logic [9:0] cnt_q   [NUM_ALARMS];
    logic [9:0] cnt_n   [NUM_ALARMS];

    always_ff @(posedge CP) begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (CR) begin
                state_q[i] <= S_IDLE;
                cnt_q[i]   <= 10'd0;
            end else begin
                state_q[i] <= state_n[i];
                cnt_q[i]   <= cnt_n[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            state_n[i] = state_q[i];
            cnt_n[i]   = cnt_q[i];
            if (!Al_En[i]) begin
                state_n[i] = S_IDLE;
            end else if (Al_Wr && wr_ok && (Al_Sel == SEL_W'(i))) begin
                // Rewriting a channel cancels whatever it was doing.
                state_n[i] = S_IDLE;
            end else begin
                case (state_q[i])
                    S_IDLE: begin
                        // Match only on a tick that lands exactly on hh:mm:00.
                        if (time_step && (sec_n == 8'h00) &&
                            (hour_n == al_hour[i]) && (min_n == al_min[i])) begin
                            state_n[i] = S_RING;
                            cnt_n[i]   = RING_LOAD;
                        end
                    end
                    S_RING: begin
                        if (Stop) begin
                            state_n[i] = S_IDLE;
                        end else if (Snooze) begin
                            state_n[i] = S_SNOOZE;
                            cnt_n[i]   = SNOOZE_LOAD;
                        end else if (tick) begin
                            if (cnt_q[i] <= 10'd1)
                                state_n[i] = S_IDLE;
                            else
                                cnt_n[i] = cnt_q[i] - 10'd1;
                        end
                    end
                    S_SNOOZE: begin
                        if (Stop) begin
                            state_n[i] = S_IDLE;
                        end else if (tick) begin
                            if (cnt_q[i] <= 10'd1) begin
                                state_n[i] = S_RING;
                                cnt_n[i]   = RING_LOAD;
                            end else begin
                                cnt_n[i] = cnt_q[i] - 10'd1;
                            end
                        end
                    end
                    default: state_n[i] = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++)
            Ring[i] = (state_q[i] == S_RING);
        BellRadio = |Ring;
    end

endmodule

// File: tb/tb_clock_core_multi_alarm.sv
// ---------------------------------------------------------------------------
// tb_clock_core_multi_alarm
//
// Directed bench for clock_core_multi_alarm with TICK_DIV=4, RING_SECS=10,
// SNOOZE_MIN=5 and two alarm channels. Inputs change on the falling edge,
// outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_clock_core_multi_alarm;

    localparam int NA = 2;
    localparam int TD = 4;

    logic          CP = 1'b0;
    logic          CR, EN, Adj_M, Adj_H, Mode24, Ld, Al_Wr, Snooze, Stop;
    logic [7:0]    Ld_Hour, Ld_Min, Al_Hour, Al_Min;
    logic [0:0]    Al_Sel;
    logic [NA-1:0] Al_En;
    logic [7:0]    Hour, Minute, Second;
    logic          PM, Tick, HourRadio, BellRadio, Err;
    logic [NA-1:0] Ring;

    int checks   = 0;
    int failures = 0;
    int hr_cnt   = 0;
    int tick_cnt = 0;
    int ring_hi  = 0;

    clock_core_multi_alarm #(
        .NUM_ALARMS(NA),
        .TICK_DIV  (TD),
        .RING_SECS (10),
        .SNOOZE_MIN(5)
    ) dut (
        .CP       (CP),
        .CR       (CR),
        .EN       (EN),
        .Adj_M    (Adj_M),
        .Adj_H    (Adj_H),
        .Mode24   (Mode24),
        .Ld       (Ld),
        .Ld_Hour  (Ld_Hour),
        .Ld_Min   (Ld_Min),
        .Al_Wr    (Al_Wr),
        .Al_Sel   (Al_Sel),
        .Al_Hour  (Al_Hour),
        .Al_Min   (Al_Min),
        .Al_En    (Al_En),
        .Snooze   (Snooze),
        .Stop     (Stop),
        .Hour     (Hour),
        .Minute   (Minute),
        .Second   (Second),
        .PM       (PM),
        .Tick     (Tick),
        .HourRadio(HourRadio),
        .Ring     (Ring),
        .BellRadio(BellRadio),
        .Err      (Err)
    );

    // Clock
    always #5 CP = ~CP;

    // One clock: from a falling edge to the next falling edge.
    task automatic cyc();
        @(posedge CP);
        @(negedge CP);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Run n whole prescaler periods, counting chime pulses and ticks.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n * TD; i++) begin
            if (HourRadio === 1'b1) hr_cnt++;
            if (Tick === 1'b1) tick_cnt++;
            cyc();
        end
    endtask

    task automatic do_ld(input logic [7:0] h, input logic [7:0] m);
        Ld_Hour = h;
        Ld_Min  = m;
        Ld      = 1'b1;
        cyc();
        Ld      = 1'b0;
    endtask

    task automatic do_al_wr(input logic [0:0] sel, input logic [7:0] h, input logic [7:0] m);
        Al_Sel  = sel;
        Al_Hour = h;
        Al_Min  = m;
        Al_Wr   = 1'b1;
        cyc();
        Al_Wr   = 1'b0;
    endtask

    initial begin
        CR = 1'b1; EN = 1'b0; Adj_M = 1'b0; Adj_H = 1'b0; Mode24 = 1'b0;
        Ld = 1'b0; Ld_Hour = 8'h00; Ld_Min = 8'h00;
        Al_Wr = 1'b0; Al_Sel = 1'b0; Al_Hour = 8'h00; Al_Min = 8'h00;
        Al_En = '0; Snooze = 1'b0; Stop = 1'b0;

        // --- Reset ---------------------------------------------------------
        @(negedge CP);
        cyc();
        cyc();
        CR = 1'b0;
        chk("rst_hour12", Hour, 8'h12);
        chk("rst_min", Minute, 8'h00);
        chk("rst_sec", Second, 8'h00);
        chk("rst_pm", PM, 1'b0);
        chk("rst_tick", Tick, 1'b0);
        chk("rst_ring", Ring, 2'b00);
        chk("rst_bell", BellRadio, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_chime", HourRadio, 1'b0);

        // --- Load 23:59 and roll over midnight ----------------------------
        Mode24 = 1'b1;
        do_ld(8'h23, 8'h59);
        chk("ld_hour", Hour, 8'h23);
        chk("ld_min", Minute, 8'h59);
        chk("ld_sec", Second, 8'h00);
        chk("ld_pm", PM, 1'b1);
        chk("ld_err", Err, 1'b0);
        EN = 1'b1;
        hr_cnt = 0; tick_cnt = 0;
        run_ticks(59);
        chk("pre_mid_sec", Second, 8'h59);
        chk("pre_mid_min", Minute, 8'h59);
        chk("pre_mid_chime", hr_cnt, 0);
        run_ticks(1);
        chk("mid_hour24", Hour, 8'h00);
        chk("mid_min", Minute, 8'h00);
        chk("mid_sec", Second, 8'h00);
        chk("mid_pm", PM, 1'b0);
        chk("mid_ticks", tick_cnt, 60);
        chk("mid_chime", hr_cnt, 1);
        Mode24 = 1'b0;
        #1;
        chk("mid_hour12", Hour, 8'h12);

        // --- EN low holds everything ---------------------------------------
        EN = 1'b0;
        tick_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (Tick === 1'b1) tick_cnt++;
            cyc();
        end
        chk("hold_ticks", tick_cnt, 0);
        chk("hold_sec", Second, 8'h00);

        // --- Minute adjust at 10:59:59 -------------------------------------
        do_ld(8'h10, 8'h59);
        EN = 1'b1;
        run_ticks(59);
        chk("adjm_pre_sec", Second, 8'h59);
        hr_cnt = 0;
        Adj_M = 1'b1;
        run_ticks(1);
        Adj_M = 1'b0;
        chk("adjm_hour", Hour, 8'h10);
        chk("adjm_min", Minute, 8'h00);
        chk("adjm_sec", Second, 8'h00);
        chk("adjm_chime", hr_cnt, 0);

        // --- Hour adjust to 13, 12h display --------------------------------
        Mode24 = 1'b1;
        Adj_H = 1'b1;
        run_ticks(3);
        Adj_H = 1'b0;
        chk("adjh_hour24", Hour, 8'h13);
        chk("adjh_min", Minute, 8'h00);
        chk("adjh_sec", Second, 8'h03);
        Mode24 = 1'b0;
        #1;
        chk("adjh_hour12", Hour, 8'h01);
        chk("adjh_pm", PM, 1'b1);
        Mode24 = 1'b1;

        // --- Alarm 0 at 07:30 ----------------------------------------------
        EN = 1'b0;
        Al_En = 2'b01;
        do_al_wr(1'b0, 8'h07, 8'h30);
        chk("alwr_err", Err, 1'b0);
        do_ld(8'h07, 8'h29);
        EN = 1'b1;
        run_ticks(59);
        cyc(); cyc(); cyc();
        chk("al_tick_cycle", Tick, 1'b1);
        chk("al_pre_ring", Ring, 2'b00);
        cyc();
        chk("al_ring_rise", Ring, 2'b01);
        chk("al_bell", BellRadio, 1'b1);
        chk("al_time_min", Minute, 8'h30);
        chk("al_time_sec", Second, 8'h00);
        run_ticks(9);
        chk("al_ring_9", Ring, 2'b01);
        run_ticks(1);
        chk("al_ring_off", Ring, 2'b00);

        // --- Snooze, then Snooze+Stop --------------------------------------
        EN = 1'b0;
        do_al_wr(1'b0, 8'h07, 8'h31);
        EN = 1'b1;
        run_ticks(50);
        chk("sn_ring", Ring, 2'b01);
        Snooze = 1'b1;
        cyc();
        Snooze = 1'b0;
        chk("sn_enter", Ring, 2'b00);
        ring_hi = 0;
        for (int i = 0; i < 299 * TD; i++) begin
            cyc();
            if (Ring !== 2'b00) ring_hi++;
        end
        chk("sn_quiet_299", ring_hi, 0);
        run_ticks(1);
        chk("sn_ring_again", Ring, 2'b01);
        Snooze = 1'b1;
        Stop = 1'b1;
        cyc();
        Snooze = 1'b0;
        Stop = 1'b0;
        chk("stop_wins", Ring, 2'b00);
        run_ticks(301);
        chk("stop_idle", Ring, 2'b00);

        // --- Two channels together -----------------------------------------
        EN = 1'b0;
        do_al_wr(1'b0, 8'h08, 8'h00);
        do_al_wr(1'b1, 8'h08, 8'h00);
        Al_En = 2'b11;
        do_ld(8'h07, 8'h59);
        EN = 1'b1;
        run_ticks(60);
        chk("dual_ring", Ring, 2'b11);
        chk("dual_bell", BellRadio, 1'b1);
        Al_En = 2'b01;
        cyc();
        chk("dual_en1_off", Ring, 2'b01);
        chk("dual_bell_keep", BellRadio, 1'b1);
        do_al_wr(1'b0, 8'h08, 8'h00);
        chk("wr_cancels", Ring, 2'b00);
        chk("wr_cancel_bell", BellRadio, 1'b0);

        // --- Rejected load and alarm write ---------------------------------
        EN = 1'b0;
        do_ld(8'h08, 8'h00);
        do_ld(8'h24, 8'h15);
        chk("badld_err", Err, 1'b1);
        chk("badld_hour", Hour, 8'h08);
        chk("badld_min", Minute, 8'h00);
        cyc();
        chk("badld_err_pulse", Err, 1'b0);
        do_al_wr(1'b1, 8'h08, 8'h5A);
        chk("badwr_err", Err, 1'b1);
        // Channel 1 must still hold 08:00.
        Al_En = 2'b10;
        do_ld(8'h07, 8'h59);
        EN = 1'b1;
        run_ticks(60);
        chk("badwr_kept", Ring, 2'b10);

        // --- Reset while ringing -------------------------------------------
        Mode24 = 1'b0;
        CR = 1'b1;
        cyc();
        chk("cr_hour", Hour, 8'h12);
        chk("cr_min", Minute, 8'h00);
        chk("cr_sec", Second, 8'h00);
        chk("cr_pm", PM, 1'b0);
        chk("cr_tick", Tick, 1'b0);
        chk("cr_chime", HourRadio, 1'b0);
        chk("cr_ring", Ring, 2'b00);
        chk("cr_bell", BellRadio, 1'b0);
        chk("cr_err", Err, 1'b0);
        CR = 1'b0;
        EN = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
